xalu_nibble_seq: RTL and testbench

- Multi-nibble sequencer that sits directly upstream of the 4-bit ALU slice, which stays outside this block.
- Latches a wide operand pair, then drives the slice one nibble per clock.
- Captures each slice output nibble into a result register and chains the slice carries between nibbles.
- Result: N×4-bit add, logic, pass and 1-bit shift operations using a single 4-bit slice.

---
 rtl/xalu_pkg.sv | 34 +++
 rtl/xalu_nibble_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_xalu_nibble_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/xalu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: slice function
// codes, sequencer FSM state encodings and small decode helpers.
package xalu_pkg;

  // Default operand width in nibbles (data width = 4 * NIBBLES).
  localparam int NIBBLES_DEFAULT = 4;

  // Slice function codes (3 bits), as understood by the external 4-bit slice.
  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_AND   = 3'd1;
  localparam logic [2:0] FN_OR    = 3'd2;
  localparam logic [2:0] FN_XOR   = 3'd3;
  localparam logic [2:0] FN_PASSA = 3'd4;
  localparam logic [2:0] FN_PASSB = 3'd5;
  localparam logic [2:0] FN_SHR   = 3'd6;
  localparam logic [2:0] FN_SHL   = 3'd7;

  // Sequencer FSM state type and encodings.
  typedef logic [1:0] xalu_state_t;
  localparam xalu_state_t ST_IDLE = 2'd0;
  localparam xalu_state_t ST_RUN  = 2'd1;
  localparam xalu_state_t ST_DONE = 2'd2;

  // True for operations that walk the operand MSB nibble first.
  function automatic logic fn_is_shr(input logic [2:0] func);
    return (func == FN_SHR);
  endfunction

  // True for operations whose carry ripples right-to-left (LSB upward).
  function automatic logic fn_is_up_carry(input logic [2:0] func);
    return (func == FN_ADD) || (func == FN_SHL);
  endfunction

endpackage

// File: rtl/xalu_nibble_seq.sv
// Multi-nibble sequencer for an external 4-bit ALU slice. A wide operand
// pair is latched on start, fed to the slice one nibble per enabled clock,
// and each slice output nibble is written into the result register while
// the slice carry is chained from one nibble to the next. Flags and the
// final carry are registered on the last capture so they are valid in the
// single DONE cycle and then hold until the next accepted start.
module xalu_nibble_seq
  import xalu_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic [2:0]             func,
  input  logic                   com,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic                   ones,
  output logic                   equal,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_f,
  output logic                   alu_com,
  output logic                   alu_ci_right,
  output logic                   alu_ci_left,
  input  logic [3:0]             alu_d,
  input  logic                   alu_co_left,
  input  logic                   alu_co_right,
  input  logic                   alu_equ
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IW-1:0] IDX_FIRST = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_LAST  = IW'(NIBBLES - 1);

  // Sequencer state and latched operation.
  xalu_state_t     r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_func;
  logic            r_com;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_eq_acc;

  // Registered outputs.
  logic [W-1:0]    r_result;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_zero;
  logic            r_ones;
  logic            r_equal;

  // Combinational helpers.
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [IW-1:0]   w_sel;
  logic [IW+1:0]   w_bit;
  logic [IW-1:0]   w_idx_next;
  logic            w_carry_next;
  logic [W-1:0]    w_res_next;
  logic            w_eq_next;

  // A start is honoured only in IDLE; a step happens on every enabled RUN clock.
  assign w_accept = ena & start & (r_state == ST_IDLE);
  assign w_step   = ena & (r_state == ST_RUN);

  // Outside RUN the slice sees nibble 0; idx may have been parked anywhere.
  assign w_sel = (r_state == ST_RUN) ? r_idx : IDX_FIRST;
  assign w_bit = {w_sel, 2'b00};

  // Slice drive: nibble selects from the latched operands plus latched mode.
  assign alu_a   = r_a[w_bit +: 4];
  assign alu_b   = r_b[w_bit +: 4];
  assign alu_f   = r_func;
  assign alu_com = r_com;

  // Carry-in routing: carry enters on the right for ADD/SHL, on the left for SHR.
  always_comb begin
    alu_ci_right = 1'b0;
    alu_ci_left  = 1'b0;
    if (fn_is_up_carry(r_func)) begin
      alu_ci_right = r_carry;
    end else if (fn_is_shr(r_func)) begin
      alu_ci_left = r_carry;
    end else begin
      alu_ci_right = 1'b0;
      alu_ci_left  = 1'b0;
    end
  end

  // Last-nibble detect and walk direction (SHR walks down, all else walks up).
  always_comb begin
    w_last     = 1'b0;
    w_idx_next = r_idx;
    if (fn_is_shr(r_func)) begin
      w_last     = (r_idx == IDX_FIRST);
      w_idx_next = r_idx - {{(IW-1){1'b0}}, 1'b1};
    end else begin
      w_last     = (r_idx == IDX_LAST);
      w_idx_next = r_idx + {{(IW-1){1'b0}}, 1'b1};
    end
  end

  // Next carry picks the slice carry-out on the side facing the next nibble.
  always_comb begin
    w_carry_next = 1'b0;
    case (r_func)
      FN_ADD:  w_carry_next = alu_co_left;
      FN_SHL:  w_carry_next = alu_co_left;
      FN_SHR:  w_carry_next = alu_co_right;
      default: w_carry_next = 1'b0;
    endcase
  end

  // Result with the current slice nibble merged in; used for capture and flags.
  always_comb begin
    w_res_next        = r_result;
    w_res_next[w_bit +: 4] = alu_d;
  end

  assign w_eq_next = r_eq_acc & alu_equ;

  // Sequencer FSM: IDLE -> RUN on accepted start, RUN -> DONE after last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      r_state <= r_state;
    end
  end

  // Operand and mode latch on accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= {W{1'b0}};
      r_b    <= {W{1'b0}};
      r_func <= 3'd0;
      r_com  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a_in;
      r_b    <= b_in;
      r_func <= func;
      r_com  <= com;
    end else begin
      r_a    <= r_a;
      r_b    <= r_b;
      r_func <= r_func;
      r_com  <= r_com;
    end
  end

  // Per-nibble datapath: index walk, carry chain, equality accumulate, capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= IDX_FIRST;
      r_carry  <= 1'b0;
      r_eq_acc <= 1'b0;
      r_result <= {W{1'b0}};
    end else if (w_accept) begin
      r_idx    <= fn_is_shr(func) ? IDX_LAST : IDX_FIRST;
      r_carry  <= cin;
      r_eq_acc <= 1'b1;
      r_result <= r_result;
    end else if (w_step) begin
      // Park idx at 0 after the last nibble so it never points out of range.
      r_idx    <= w_last ? IDX_FIRST : w_idx_next;
      r_carry  <= w_carry_next;
      r_eq_acc <= w_eq_next;
      r_result <= w_res_next;
    end else begin
      r_idx    <= r_idx;
      r_carry  <= r_carry;
      r_eq_acc <= r_eq_acc;
      r_result <= r_result;
    end
  end

  // Status outputs: busy spans RUN, flags are registered on the final capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_ones  <= 1'b0;
      r_equal <= 1'b0;
    end else if (!ena) begin
      r_busy  <= r_busy;
      r_done  <= r_done;
      r_cout  <= r_cout;
      r_zero  <= r_zero;
      r_ones  <= r_ones;
      r_equal <= r_equal;
    end else if (w_accept) begin
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_cout  <= r_cout;
      r_zero  <= r_zero;
      r_ones  <= r_ones;
      r_equal <= r_equal;
    end else if (w_step && w_last) begin
      // cout is the true carry: COM only inverts data inside the slice.
      r_busy  <= 1'b0;
      r_done  <= 1'b1;
      r_cout  <= w_carry_next;
      r_zero  <= (w_res_next == {W{1'b0}});
      r_ones  <= (w_res_next == {W{1'b1}});
      r_equal <= w_eq_next;
    end else begin
      r_busy  <= r_busy;
      r_done  <= 1'b0;
      r_cout  <= r_cout;
      r_zero  <= r_zero;
      r_ones  <= r_ones;
      r_equal <= r_equal;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;
  assign ones   = r_ones;
  assign equal  = r_equal;

endmodule

// File: tb/tb_xalu_nibble_seq.sv
// Scoreboard bench for xalu_nibble_seq with a behavioural 4-bit slice.
// The driver pushes hand-computed expectations; a negedge monitor pops and
// compares them whenever done pulses.
module tb_xalu_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          start;
  logic [2:0]    func;
  logic          com;
  logic          cin;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          zero;
  logic          ones;
  logic          equal;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_f;
  logic          alu_com;
  logic          alu_ci_right;
  logic          alu_ci_left;
  logic [3:0]    alu_d;
  logic          alu_co_left;
  logic          alu_co_right;
  logic          alu_equ;

  xalu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .func(func),
    .com(com), .cin(cin), .a_in(a_in), .b_in(b_in), .busy(busy),
    .done(done), .result(result), .cout(cout), .zero(zero), .ones(ones),
    .equal(equal), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_com(alu_com), .alu_ci_right(alu_ci_right), .alu_ci_left(alu_ci_left),
    .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
    .alu_equ(alu_equ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the external 4-bit slice.
  always_comb begin
    alu_d        = 4'h0;
    alu_co_left  = 1'b0;
    alu_co_right = 1'b0;
    case (alu_f)
      3'd0: {alu_co_left, alu_d} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_ci_right};
      3'd1: alu_d = alu_a & alu_b;
      3'd2: alu_d = alu_a | alu_b;
      3'd3: alu_d = alu_a ^ alu_b;
      3'd4: alu_d = alu_a;
      3'd5: alu_d = alu_b;
      3'd6: begin alu_d = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
      3'd7: begin alu_d = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
      default: alu_d = 4'h0;
    endcase
    if (alu_com) alu_d = ~alu_d;
  end
  assign alu_equ = (alu_a == alu_b);

  typedef struct {
    string        nm;
    logic [15:0]  res;
    logic         co;
    logic         zr;
    logic         on;
    logic         eq;
    logic [15:0]  seq;
    int           busy_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor state.
  int          mon_busy;
  logic [15:0] mon_seq;

  // Monitor: track busy length and nibble order, compare on each done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 0;
      mon_seq  = 16'h0000;
    end else begin
      if (busy) begin
        mon_busy = mon_busy + 1;
        if (ena) mon_seq = {mon_seq[11:0], alu_a};
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (result 0x%0h)", result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.nm, ".result"}, 32'(result), 32'(e.res));
          chk({e.nm, ".cout"},   32'(cout),   32'(e.co));
          chk({e.nm, ".zero"},   32'(zero),   32'(e.zr));
          chk({e.nm, ".ones"},   32'(ones),   32'(e.on));
          chk({e.nm, ".equal"},  32'(equal),  32'(e.eq));
          chk({e.nm, ".busy_cycles"}, 32'(mon_busy), 32'(e.busy_cyc));
          chk({e.nm, ".nibble_order"}, 32'(mon_seq), 32'(e.seq));
        end
        mon_busy = 0;
        mon_seq  = 16'h0000;
      end
    end
  end

  // Wait (bounded) for the done pulse of an accepted operation.
  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: got no done expected done within 40 cycles", nm);
    end
  endtask

  // Issue one operation; optionally pulse a spurious start or stall with ena.
  task automatic run_op(input string nm, input logic [2:0] f, input logic c,
                        input logic ci, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eco, input logic ez,
                        input logic eo, input logic eeq, input logic [15:0] eseq,
                        input int ebusy, input bit dup_start, input bit ena_gap);
    exp_t e;
    e.nm = nm; e.res = er; e.co = eco; e.zr = ez; e.on = eo; e.eq = eeq;
    e.seq = eseq; e.busy_cyc = ebusy;
    sb_q.push_back(e);
    @(posedge clk); #2;
    func = f; com = c; cin = ci; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    if (dup_start) begin
      @(posedge clk); #2;
      func = 3'd0; a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
    end
    if (ena_gap) begin
      @(posedge clk); #2;
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      ena = 1'b1;
    end
    wait_done(nm);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; func = 3'd0; com = 1'b0;
    cin = 1'b0; a_in = 16'h0000; b_in = 16'h0000;
    #3;
    chk("reset.busy",   32'(busy),   32'd0);
    chk("reset.done",   32'(done),   32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.cout",   32'(cout),   32'd0);
    chk("reset.zero",   32'(zero),   32'd0);
    chk("reset.ones",   32'(ones),   32'd0);
    chk("reset.equal",  32'(equal),  32'd0);
    chk("reset.alu_a",  32'(alu_a),  32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    //      name        f     com  cin  a         b         result    co   zr   on   eq   seq       busy dup ena
    run_op("add1",     3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4321, 4, 1'b0, 1'b0);
    run_op("add_wrap", 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 4, 1'b0, 1'b0);
    run_op("shr",      3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8001, 4, 1'b0, 1'b0);
    run_op("shl",      3'd7, 1'b0, 1'b0, 16'h8421, 16'h0000, 16'h0842, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1248, 4, 1'b0, 1'b0);
    run_op("xor_com",  3'd3, 1'b1, 1'b0, 16'h00FF, 16'h00FF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFF00, 4, 1'b0, 1'b0);
    run_op("or",       3'd2, 1'b0, 1'b1, 16'h0F0F, 16'h3030, 16'h3F3F, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF0F0, 4, 1'b0, 1'b0);
    run_op("and",      3'd1, 1'b0, 1'b0, 16'hF0F0, 16'hFFFF, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0F0F, 4, 1'b0, 1'b0);
    run_op("passa_com",3'd4, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'hEDCB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 4, 1'b0, 1'b0);
    run_op("passb",    3'd5, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4, 1'b0, 1'b0);
    run_op("busy_start",3'd0,1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 4, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_start.result_held", 32'(result), 32'h0007);
    chk("busy_start.idle", 32'(busy), 32'd0);
    run_op("ena_stall",3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 7, 1'b0, 1'b1);

    // Abort mid-RUN with reset: no done may follow.
    @(posedge clk); #2;
    func = 3'd0; com = 1'b1; cin = 1'b1; a_in = 16'h5555; b_in = 16'h1111; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy",   32'(busy),   32'd0);
    chk("abort.done",   32'(done),   32'd0);
    chk("abort.result", 32'(result), 32'd0);
    chk("abort.cout",   32'(cout),   32'd0);
    chk("abort.equal",  32'(equal),  32'd0);
    chk("abort.alu_a",  32'(alu_a),  32'd0);
    chk("abort.alu_com",32'(alu_com),32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort.no_done_result", 32'(result), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
